// File: rtl/ram_sweep_tester.sv
// Front-panel SRAM exerciser: fill-and-verify with an incrementing pattern, or
// step-by-step dump of memory onto the lights.
module ram_sweep_tester #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 18,
  parameter int COUNT  = 10,
  parameter int STEP   = 1,
  parameter int IDX_W  = $clog2(COUNT + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0]       SW,
  input  logic              Step,
  input  logic              Mode,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN,
  output logic [15:0]       Light,
  output logic [IDX_W-1:0]  Index,
  output logic              Busy,
  output logic              Done,
  output logic              Fail,
  output logic [IDX_W-1:0]  FailIdx
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GET_SEED  = 4'd1,
    S_WR_SET    = 4'd2,
    S_WR_PULSE  = 4'd3,
    S_RD_SET    = 4'd4,
    S_RD_CMP    = 4'd5,
    S_DONE      = 4'd6,
    S_DUMP_WAIT = 4'd7,
    S_DUMP_SET  = 4'd8,
    S_DUMP_CMP  = 4'd9
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(COUNT - 1);
  localparam logic [DATA_W-1:0] STEP_D   = DATA_W'(STEP);

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [DATA_W-1:0]   seed_r;
  logic [DATA_W-1:0]   pat_r;
  logic                drive_r;
  logic [IDX_W-1:0]    idx_next_s;

  function automatic logic [15:0] to_light(input logic [DATA_W-1:0] d);
    return 16'(d);
  endfunction

  // Address arithmetic wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] b,
                                                input logic [IDX_W-1:0] i);
    return b + ADDR_W'(i);
  endfunction

  assign idx_next_s = Index + {{(IDX_W-1){1'b0}}, 1'b1};
  assign Ram1Data   = drive_r ? pat_r : {DATA_W{1'bz}};

  // Sweep sequencer; every output is a register updated on the transition into its state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= S_IDLE;
      base_r   <= {ADDR_W{1'b0}};
      seed_r   <= {DATA_W{1'b0}};
      pat_r    <= {DATA_W{1'b0}};
      drive_r  <= 1'b0;
      Ram1Addr <= {ADDR_W{1'b0}};
      Ram1OE   <= 1'b1;
      Ram1WE   <= 1'b1;
      Ram1EN   <= 1'b1;
      Light    <= 16'h0000;
      Index    <= {IDX_W{1'b0}};
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Fail     <= 1'b0;
      FailIdx  <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (Step) begin
            base_r <= ADDR_W'(SW);
            Light  <= SW;
            Index  <= {IDX_W{1'b0}};
            if (Mode) begin
              Ram1Addr <= ADDR_W'(SW);
              Ram1EN   <= 1'b0;
              Ram1OE   <= 1'b0;
              Busy     <= 1'b1;
              state_r  <= S_DUMP_SET;
            end else begin
              state_r  <= S_GET_SEED;
            end
          end
        end
        S_GET_SEED: begin
          if (Step) begin
            seed_r   <= DATA_W'(SW);
            pat_r    <= DATA_W'(SW);
            Light    <= SW;
            Ram1Addr <= base_r;
            Ram1EN   <= 1'b0;
            drive_r  <= 1'b1;
            Busy     <= 1'b1;
            state_r  <= S_WR_SET;
          end
        end
        S_WR_SET: begin
          Ram1WE  <= 1'b0;
          state_r <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          // WE rises together with the bus release, never after it.
          Ram1WE <= 1'b1;
          if (Index == LAST_IDX) begin
            drive_r  <= 1'b0;
            Index    <= {IDX_W{1'b0}};
            Ram1Addr <= base_r;
            pat_r    <= seed_r;
            Ram1OE   <= 1'b0;
            state_r  <= S_RD_SET;
          end else begin
            Index    <= idx_next_s;
            Ram1Addr <= addr_at(base_r, idx_next_s);
            pat_r    <= pat_r + STEP_D;
            Light    <= to_light(pat_r + STEP_D);
            state_r  <= S_WR_SET;
          end
        end
        S_RD_SET: begin
          state_r <= S_RD_CMP;
        end
        S_RD_CMP: begin
          if ((Ram1Data != pat_r) && !Fail) begin
            Fail    <= 1'b1;
            FailIdx <= Index;
            Light   <= to_light(Ram1Data);
          end
          if (Index == LAST_IDX) begin
            Ram1OE  <= 1'b1;
            Ram1EN  <= 1'b1;
            Busy    <= 1'b0;
            state_r <= S_DONE;
          end else begin
            Index    <= idx_next_s;
            Ram1Addr <= addr_at(base_r, idx_next_s);
            pat_r    <= pat_r + STEP_D;
            state_r  <= S_RD_SET;
          end
        end
        S_DONE: begin
          Done <= 1'b1;
          if (!Fail) begin
            Light <= 16'hFFFF;
          end
          if (Step) begin
            Done    <= 1'b0;
            Fail    <= 1'b0;
            FailIdx <= {IDX_W{1'b0}};
            Index   <= {IDX_W{1'b0}};
            state_r <= S_IDLE;
          end
        end
        S_DUMP_SET: begin
          state_r <= S_DUMP_CMP;
        end
        S_DUMP_CMP: begin
          Light   <= to_light(Ram1Data);
          Ram1OE  <= 1'b1;
          Ram1EN  <= 1'b1;
          Busy    <= 1'b0;
          state_r <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          if (Step) begin
            if (Index == LAST_IDX) begin
              Fail    <= 1'b0;
              state_r <= S_DONE;
            end else begin
              Index    <= idx_next_s;
              Ram1Addr <= addr_at(base_r, idx_next_s);
              Ram1OE   <= 1'b0;
              Ram1EN   <= 1'b0;
              Busy     <= 1'b1;
              state_r  <= S_DUMP_SET;
            end
          end
        end
        default: begin
          drive_r <= 1'b0;
          Ram1OE  <= 1'b1;
          Ram1WE  <= 1'b1;
          Ram1EN  <= 1'b1;
          Busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sweep_tester.sv
// Directed bench: two sweeper instances (defaults, and STEP=3/ADDR_W=16/COUNT=4)
// each wired to a small behavioural SRAM model.
module tb_ram_sweep_tester;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic        mode;
  logic        step_a;
  logic        step_b;

  // Instance A: default parameters
  logic [17:0] addr_a;
  wire  [15:0] bus_a;
  logic        oe_a, we_a, en_a, busy_a, done_a, fail_a;
  logic [15:0] light_a;
  logic [3:0]  index_a, failidx_a;

  // Instance B: STEP=3, ADDR_W=16, COUNT=4
  logic [15:0] addr_b;
  wire  [15:0] bus_b;
  logic        oe_b, we_b, en_b, busy_b, done_b, fail_b;
  logic [15:0] light_b;
  logic [2:0]  index_b, failidx_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int contention_a = 0;
  logic corrupt;

  logic [15:0] mem_a [logic [31:0]];
  logic [15:0] mem_b [logic [31:0]];
  logic [15:0] rd_a, rd_b;

  ram_sweep_tester dut_a (
    .CLK(clk), .RST(rst_n), .SW(sw), .Step(step_a), .Mode(mode),
    .Ram1Addr(addr_a), .Ram1Data(bus_a), .Ram1OE(oe_a), .Ram1WE(we_a), .Ram1EN(en_a),
    .Light(light_a), .Index(index_a), .Busy(busy_a), .Done(done_a), .Fail(fail_a),
    .FailIdx(failidx_a)
  );

  ram_sweep_tester #(.DATA_W(16), .ADDR_W(16), .COUNT(4), .STEP(3)) dut_b (
    .CLK(clk), .RST(rst_n), .SW(sw), .Step(step_b), .Mode(mode),
    .Ram1Addr(addr_b), .Ram1Data(bus_b), .Ram1OE(oe_b), .Ram1WE(we_b), .Ram1EN(en_b),
    .Light(light_b), .Index(index_b), .Busy(busy_b), .Done(done_b), .Fail(fail_b),
    .FailIdx(failidx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: write captured as WE falls (address/data already stable),
  // read data presented while EN and OE are both low.
  always @(negedge we_a) if (!en_a) mem_a[32'(addr_a)] = bus_a;
  always @(negedge we_b) if (!en_b) mem_b[32'(addr_b)] = bus_b;

  always @(negedge clk) begin
    rd_a = mem_a.exists(32'(addr_a)) ? mem_a[32'(addr_a)] : 16'hDEAD;
    if (corrupt && (addr_a == 18'h00103 || addr_a == 18'h00107)) rd_a = rd_a ^ 16'h8000;
    rd_b = mem_b.exists(32'(addr_b)) ? mem_b[32'(addr_b)] : 16'hDEAD;
    if (!oe_a && !we_a) contention_a++;
  end

  assign bus_a = (!oe_a && !en_a) ? rd_a : 16'bz;
  assign bus_b = (!oe_b && !en_b) ? rd_b : 16'bz;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_a(input logic [15:0] v, input logic m);
    @(negedge clk);
    sw = v; mode = m; step_a = 1'b1;
    @(negedge clk);
    step_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [15:0] v, input logic m);
    @(negedge clk);
    sw = v; mode = m; step_b = 1'b1;
    @(negedge clk);
    step_b = 1'b0;
  endtask

  task automatic wait_done_a(input int start, output int n);
    n = start;
    while (!done_a && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done_b(input int start, output int n);
    n = start;
    while (!done_b && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = 16'h0000; mode = 1'b0; step_a = 1'b0; step_b = 1'b0; corrupt = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_en", {31'd0, en_a}, 32'd1);
    check_val("rst_we", {31'd0, we_a}, 32'd1);
    check_val("rst_oe", {31'd0, oe_a}, 32'd1);
    check_val("rst_addr", 32'(addr_a), 32'd0);
    check_val("rst_light", 32'(light_a), 32'd0);
    check_val("rst_flags", {28'd0, busy_a, done_a, fail_a, 1'b0}, 32'd0);
    check_val("rst_idx", {24'd0, index_a, failidx_a}, 32'd0);
    rst_n = 1'b1;

    // Fill-and-verify, clean memory
    pulse_a(16'h0100, 1'b0);
    check_val("base_light", 32'(light_a), 32'h0100);
    check_val("getseed_busy", {31'd0, busy_a}, 32'd0);
    pulse_a(16'h0005, 1'b0);
    check_val("wrset_addr", 32'(addr_a), 32'h0100);
    check_val("wrset_ctl", {29'd0, en_a, we_a, oe_a}, 32'b011);
    check_val("wrset_light", 32'(light_a), 32'h0005);
    check_val("wr_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    check_val("wrpulse_we", {31'd0, we_a}, 32'd0);
    wait_done_a(1, cyc);
    check_val("latency", cyc, 32'd41);
    check_val("pass_fail", {31'd0, fail_a}, 32'd0);
    @(negedge clk);
    check_val("pass_light", 32'(light_a), 32'hFFFF);
    check_val("mem_first", 32'(mem_a[32'h100]), 32'h0005);
    check_val("mem_last", 32'(mem_a[32'h109]), 32'h000E);
    pulse_a(16'h0000, 1'b0);
    check_val("idle_clear", {28'd0, done_a, fail_a, 2'b00}, 32'd0);

    // Same run with reads of 0x103 and 0x107 corrupted
    corrupt = 1'b1;
    pulse_a(16'h0100, 1'b0);
    pulse_a(16'h0005, 1'b0);
    wait_done_a(0, cyc);
    @(negedge clk);
    check_val("bad_done", {31'd0, done_a}, 32'd1);
    check_val("bad_fail", {31'd0, fail_a}, 32'd1);
    check_val("bad_failidx", 32'(failidx_a), 32'd3);
    check_val("bad_light", 32'(light_a), 32'h8008);
    corrupt = 1'b0;
    pulse_a(16'h0000, 1'b0);

    // Dump mode, one word per Step
    for (int k = 0; k < 10; k++) begin
      pulse_a((k == 0) ? 16'h0100 : 16'h0000, (k == 0));
      repeat (2) @(negedge clk);
      check_val($sformatf("dump_light%0d", k), 32'(light_a), 32'h0005 + k);
      check_val($sformatf("dump_idx%0d", k), 32'(index_a), k);
    end
    pulse_a(16'h0000, 1'b0);
    @(negedge clk);
    check_val("dump_done", {30'd0, done_a, fail_a}, 32'b10);
    pulse_a(16'h0000, 1'b0);

    // Asynchronous reset in the middle of a write pulse
    pulse_a(16'h0200, 1'b0);
    pulse_a(16'h0011, 1'b0);
    @(negedge clk);
    check_val("mid_we_low", {31'd0, we_a}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_ctl", {29'd0, en_a, we_a, oe_a}, 32'b111);
    check_val("arst_outs", {addr_a[15:0], light_a}, 32'd0);
    check_val("arst_flags", {24'd0, busy_a, done_a, fail_a, 1'b0, index_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Step during Busy is ignored
    pulse_a(16'h0300, 1'b0);
    pulse_a(16'h0020, 1'b0);
    repeat (3) @(negedge clk);
    pulse_a(16'hAAAA, 1'b1);
    wait_done_a(5, cyc);
    check_val("busy_step_latency", cyc, 32'd41);
    @(negedge clk);
    check_val("busy_step_light", 32'(light_a), 32'hFFFF);
    check_val("busy_step_mem", 32'(mem_a[32'h309]), 32'h0029);
    check_val("no_contention", contention_a, 32'd0);

    // Instance B: STEP=3 pattern wrap and address wrap from 0xFFFF
    pulse_b(16'hFFFF, 1'b0);
    pulse_b(16'hFFFE, 1'b0);
    wait_done_b(0, cyc);
    check_val("b_latency", cyc, 32'd17);
    @(negedge clk);
    check_val("b_fail", {31'd0, fail_b}, 32'd0);
    check_val("b_light", 32'(light_b), 32'hFFFF);
    check_val("b_mem_ffff", 32'(mem_b[32'hFFFF]), 32'hFFFE);
    check_val("b_mem_0000", 32'(mem_b[32'h0000]), 32'h0001);
    check_val("b_mem_0002", 32'(mem_b[32'h0002]), 32'h0007);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
